// File: rtl/i3c_sdr_rd_serializer.sv
// SDR read-data serializer: shifts TX bytes MSB first onto SDA and presents the ninth bit
// (I3C T-bit or I2C ACK slot) one SCL rising edge ahead of the pad-output register stage.
module i3c_sdr_rd_serializer #(
  parameter int TBIT_MODE = 1,
  parameter int CNT_W     = 8
) (
  input  logic             clk_SCL,
  input  logic             RST,
  input  logic             start_read,
  input  logic             abort,
  input  logic             sda_in,
  input  logic [7:0]       tx_data,
  input  logic             tx_valid,
  input  logic             tx_last,
  output logic             tx_ready,
  output logic             pin_SDA_out,
  output logic             pin_SDA_oena,
  output logic             pin_SDA_oena_rise0,
  output logic             rd_done,
  output logic [1:0]       rd_status,
  output logic [CNT_W-1:0] byte_cnt
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DATA  = 2'd1,
    S_NINTH = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [1:0] ST_END      = 2'b00;
  localparam logic [1:0] ST_NACK     = 2'b01;
  localparam logic [1:0] ST_UNDERRUN = 2'b10;
  localparam logic [1:0] ST_ABORT    = 2'b11;

  state_t           state_q, state_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             last_q, last_d;
  logic             armed_q, armed_d;
  logic             out_q, out_d;
  logic             oena_q, oena_d;
  logic             rise0_q, rise0_d;
  logic [1:0]       status_q, status_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic start_ok;
  logic cont;
  logic oena_eff;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  // {out, oena, rise0} for the ninth bit. A continue T-bit is driven high and then
  // released while SCL is high so the master can still abort the read.
  function automatic logic [2:0] ninth_bits(input logic last);
    if (TBIT_MODE != 0) return last ? 3'b010 : 3'b111;
    else                return 3'b000;
  endfunction

  assign start_ok = (state_q == S_IDLE) & start_read & armed_q & ~abort;
  assign cont     = (TBIT_MODE != 0) ? ~last_q : ~sda_in;
  assign tx_ready = start_ok | ((state_q == S_NINTH) & cont & ~abort);

  always_comb begin
    state_d   = state_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    last_d    = last_q;
    armed_d   = armed_q | ~start_read;
    out_d     = out_q;
    oena_d    = oena_q;
    rise0_d   = rise0_q;
    status_d  = status_q;
    cnt_d     = cnt_q;

    case (state_q)
      S_IDLE: begin
        if (start_ok) begin
          armed_d = 1'b0;
          cnt_d   = '0;
          if (tx_valid) begin
            shift_d   = tx_data;
            last_d    = tx_last;
            bit_idx_d = 3'd7;
            out_d     = tx_data[7];
            oena_d    = 1'b1;
            rise0_d   = 1'b0;
            state_d   = S_DATA;
          end else begin
            status_d = ST_UNDERRUN;
            out_d    = 1'b0;
            oena_d   = 1'b0;
            rise0_d  = 1'b0;
            state_d  = S_DONE;
          end
        end
      end

      S_DATA: begin
        if (abort) begin
          status_d = ST_ABORT;
          out_d    = 1'b0;
          oena_d   = 1'b0;
          rise0_d  = 1'b0;
          state_d  = S_DONE;
        end else if (bit_idx_q != 3'd0) begin
          bit_idx_d = bit_idx_q - 3'd1;
          shift_d   = {shift_q[6:0], 1'b0};
          out_d     = shift_q[6];
        end else begin
          {out_d, oena_d, rise0_d} = ninth_bits(last_q);
          cnt_d   = sat_inc(cnt_q);
          state_d = S_NINTH;
        end
      end

      S_NINTH: begin
        // Abort wins over a byte that is being offered on the same edge.
        if (abort) begin
          status_d = ST_ABORT;
          out_d    = 1'b0;
          oena_d   = 1'b0;
          rise0_d  = 1'b0;
          state_d  = S_DONE;
        end else if (cont && tx_valid) begin
          shift_d   = tx_data;
          last_d    = tx_last;
          bit_idx_d = 3'd7;
          out_d     = tx_data[7];
          oena_d    = 1'b1;
          rise0_d   = 1'b0;
          state_d   = S_DATA;
        end else begin
          if (cont)                status_d = ST_UNDERRUN;
          else if (TBIT_MODE != 0) status_d = ST_END;
          else                     status_d = ST_NACK;
          out_d   = 1'b0;
          oena_d  = 1'b0;
          rise0_d = 1'b0;
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
        out_d   = 1'b0;
        oena_d  = 1'b0;
        rise0_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_SCL) begin
    if (RST) begin
      state_q   <= S_IDLE;
      bit_idx_q <= 3'd0;
      armed_q   <= 1'b1;
      out_q     <= 1'b0;
      oena_q    <= 1'b0;
      rise0_q   <= 1'b0;
      status_q  <= ST_END;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      bit_idx_q <= bit_idx_d;
      armed_q   <= armed_d;
      out_q     <= out_d;
      oena_q    <= oena_d;
      rise0_q   <= rise0_d;
      status_q  <= status_d;
      cnt_q     <= cnt_d;
    end
  end

  always_ff @(posedge clk_SCL) begin
    shift_q <= shift_d;
    last_q  <= last_d;
  end

  // Abort releases the pad immediately, without waiting for the next SCL edge.
  assign oena_eff           = oena_q & ~abort;
  assign pin_SDA_oena       = oena_eff;
  assign pin_SDA_oena_rise0 = rise0_q & ~abort;
  assign pin_SDA_out        = out_q & oena_eff;
  assign rd_done            = (state_q == S_DONE);
  assign rd_status          = status_q;
  assign byte_cnt           = cnt_q;

endmodule

// File: tb/tb_i3c_sdr_rd_serializer.sv
// Scoreboard bench: two serializers (T-bit and ACK mode) share stimulus; per-cycle
// expected pad values are queued as stimulus is driven and compared on the falling edge.
module tb_i3c_sdr_rd_serializer;

  typedef logic [4:0] obs_t;  // {out, oena, rise0, tx_ready, rd_done}

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_read = 1'b0;
  logic       abort_i = 1'b0;
  logic       sda_i = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_last = 1'b0;

  logic       rdy1, out1, oena1, rise1, done1;
  logic [1:0] status1;
  logic [7:0] cnt1;
  logic       rdy0, out0, oena0, rise0, done0;
  logic [1:0] status0;
  logic [1:0] cnt0;

  int    checks = 0;
  int    failures = 0;
  obs_t  exp_q[$];
  logic  sel = 1'b1;
  string tname = "init";

  always #5 clk = ~clk;

  i3c_sdr_rd_serializer #(.TBIT_MODE(1), .CNT_W(8)) dut1 (
    .clk_SCL(clk), .RST(rst), .start_read(start_read), .abort(abort_i), .sda_in(sda_i),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_last(tx_last), .tx_ready(rdy1),
    .pin_SDA_out(out1), .pin_SDA_oena(oena1), .pin_SDA_oena_rise0(rise1),
    .rd_done(done1), .rd_status(status1), .byte_cnt(cnt1)
  );

  i3c_sdr_rd_serializer #(.TBIT_MODE(0), .CNT_W(2)) dut0 (
    .clk_SCL(clk), .RST(rst), .start_read(start_read), .abort(abort_i), .sda_in(sda_i),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_last(tx_last), .tx_ready(rdy0),
    .pin_SDA_out(out0), .pin_SDA_oena(oena0), .pin_SDA_oena_rise0(rise0),
    .rd_done(done0), .rd_status(status0), .byte_cnt(cnt0)
  );

  task automatic chk(input string tag, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  task automatic push(input logic o, input logic oe, input logic r, input logic rdy, input logic d);
    exp_q.push_back({o, oe, r, rdy, d});
  endtask

  task automatic push_bits(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) push(b[i], 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic cyc();
    obs_t a;
    obs_t e;
    @(negedge clk);
    a = sel ? {out1, oena1, rise1, rdy1, done1} : {out0, oena0, rise0, rdy0, done0};
    if (exp_q.size() == 0) begin
      chk({tname, "_sb_underflow"}, 8'(exp_q.size()), 8'd1);
    end else begin
      e = exp_q.pop_front();
      chk(tname, 8'(a), 8'(e));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; start_read = 1'b0; abort_i = 1'b0; sda_i = 1'b0;
    tx_valid = 1'b0; tx_last = 1'b0; tx_data = 8'h00;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic drain();
    chk({tname, "_sb_drain"}, 8'(exp_q.size()), 8'd0);
  endtask

  // Starts a read with byte b presented in IDLE, then queues its eight data bits.
  task automatic start_byte(input logic [7:0] b, input logic last);
    push(0, 0, 0, 1, 0);
    start_read = 1'b1; tx_valid = 1'b1; tx_data = b; tx_last = last;
    cyc();
    tx_valid = 1'b0;
    push_bits(b);
    repeat (8) cyc();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    tname = "reset"; sel = 1'b1;
    do_reset();
    push(0, 0, 0, 0, 0);
    cyc();
    chk("reset_status1", 8'(status1), 8'h0);
    chk("reset_cnt1", cnt1, 8'h0);
    chk("reset_status0", 8'(status0), 8'h0);
    chk("reset_cnt0", 8'(cnt0), 8'h0);
    chk("reset_done0", 8'(done0), 8'h0);
    drain();

    // Single last byte, T-bit low
    tname = "t1_a5"; sel = 1'b1;
    do_reset();
    start_byte(8'hA5, 1'b1);
    push(0, 1, 0, 0, 0);
    cyc();
    chk("t1_status", 8'(status1), 8'h0);
    chk("t1_cnt", cnt1, 8'd1);
    push(0, 0, 0, 0, 1);
    cyc();
    push(0, 0, 0, 0, 0);   // start_read still high: not re-armed
    cyc();
    start_read = 1'b0;
    drain();

    // Two bytes, continue T-bit between them
    tname = "t2_3c_ff"; sel = 1'b1;
    do_reset();
    start_byte(8'h3C, 1'b0);
    chk("t2_cnt_mid", cnt1, 8'd1);
    push(1, 1, 1, 1, 0);
    tx_valid = 1'b1; tx_data = 8'hFF; tx_last = 1'b1;
    cyc();
    tx_valid = 1'b0;
    push_bits(8'hFF);
    repeat (8) cyc();
    push(0, 1, 0, 0, 0);
    cyc();
    chk("t2_status", 8'(status1), 8'h0);
    chk("t2_cnt", cnt1, 8'd2);
    push(0, 0, 0, 0, 1);
    cyc();
    start_read = 1'b0;
    drain();

    // Underrun at a continue T-bit
    tname = "t3_underrun"; sel = 1'b1;
    do_reset();
    start_byte(8'h12, 1'b0);
    push(1, 1, 1, 1, 0);
    cyc();
    chk("t3_status", 8'(status1), 8'h2);
    chk("t3_cnt", cnt1, 8'd1);
    push(0, 0, 0, 0, 1);
    cyc();
    start_read = 1'b0;
    drain();

    // I2C mode: ACK then NACK
    tname = "t4_i2c"; sel = 1'b0;
    do_reset();
    sda_i = 1'b1;
    start_byte(8'h81, 1'b0);
    chk("t4_cnt_mid", 8'(cnt0), 8'd1);
    sda_i = 1'b0; tx_valid = 1'b1; tx_data = 8'h7E;
    push(0, 0, 0, 1, 0);
    cyc();
    tx_valid = 1'b0; sda_i = 1'b1;
    push_bits(8'h7E);
    repeat (8) cyc();
    push(0, 0, 0, 0, 0);
    cyc();
    chk("t4_status", 8'(status0), 8'h1);
    chk("t4_cnt", 8'(cnt0), 8'd2);
    push(0, 0, 0, 0, 1);
    cyc();
    start_read = 1'b0;
    drain();

    // Abort at bit index 4
    tname = "t5_abort"; sel = 1'b1;
    do_reset();
    push(0, 0, 0, 1, 0);
    start_read = 1'b1; tx_valid = 1'b1; tx_data = 8'hF0; tx_last = 1'b0;
    cyc();
    tx_valid = 1'b0;
    for (int i = 0; i < 3; i++) push(1, 1, 0, 0, 0);
    repeat (3) cyc();
    abort_i = 1'b1;
    push(0, 0, 0, 0, 0);
    cyc();
    abort_i = 1'b0;
    chk("t5_status", 8'(status1), 8'h3);
    push(0, 0, 0, 0, 1);
    cyc();
    push(0, 0, 0, 0, 0);
    cyc();
    chk("t5_status_hold", 8'(status1), 8'h3);
    start_read = 1'b0;
    drain();

    // Abort at a continue T-bit beats a simultaneous load
    tname = "t5b_abort_t"; sel = 1'b1;
    do_reset();
    start_byte(8'h3C, 1'b0);
    abort_i = 1'b1; tx_valid = 1'b1; tx_data = 8'h99;
    push(0, 0, 0, 0, 0);
    cyc();
    abort_i = 1'b0; tx_valid = 1'b0;
    chk("t5b_status", 8'(status1), 8'h3);
    push(0, 0, 0, 0, 1);
    cyc();
    start_read = 1'b0;
    push(0, 0, 0, 0, 0);
    cyc();
    drain();

    // RST at bit index 2, then a clean read
    tname = "t6_rst"; sel = 1'b1;
    push(0, 0, 0, 1, 0);
    start_read = 1'b1; tx_valid = 1'b1; tx_data = 8'h96; tx_last = 1'b1;
    cyc();
    tx_valid = 1'b0;
    for (int i = 7; i >= 3; i--) push(tx_data[i], 1, 0, 0, 0);
    repeat (5) cyc();
    rst = 1'b1;
    push(tx_data[2], 1, 0, 0, 0);
    cyc();
    rst = 1'b0; start_read = 1'b0;
    push(0, 0, 0, 0, 0);
    cyc();
    chk("t6_status_rst", 8'(status1), 8'h0);
    chk("t6_cnt_rst", cnt1, 8'd0);
    start_byte(8'h55, 1'b1);
    push(0, 1, 0, 0, 0);
    cyc();
    chk("t6_status", 8'(status1), 8'h0);
    chk("t6_cnt", cnt1, 8'd1);
    push(0, 0, 0, 0, 1);
    cyc();
    start_read = 1'b0;
    drain();

    // No byte available at start: underrun, SDA never driven
    tname = "t7_start_underrun"; sel = 1'b1;
    do_reset();
    push(0, 0, 0, 1, 0);
    start_read = 1'b1; tx_valid = 1'b0;
    cyc();
    chk("t7_status", 8'(status1), 8'h2);
    chk("t7_cnt", cnt1, 8'd0);
    push(0, 0, 0, 0, 1);
    cyc();
    start_read = 1'b0;
    drain();

    // byte_cnt saturation on the 2-bit counter: five bytes sent, counter stops at 3
    tname = "t8_sat"; sel = 1'b0;
    do_reset();
    sda_i = 1'b1;
    start_byte(8'h11, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      sda_i = 1'b0; tx_valid = 1'b1; tx_data = 8'(8'h11 * (k + 1));
      push(0, 0, 0, 1, 0);
      cyc();
      tx_valid = 1'b0; sda_i = 1'b1;
      push_bits(tx_data);
      repeat (8) cyc();
    end
    push(0, 0, 0, 0, 0);
    cyc();
    chk("t8_cnt_sat", 8'(cnt0), 8'd3);
    chk("t8_status", 8'(status0), 8'h1);
    push(0, 0, 0, 0, 1);
    cyc();
    start_read = 1'b0;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/i3c_sdr_rd_serializer.md
Name: i3c_sdr_rd_serializer

Overview:
- Upstream stage feeding the SDA pad-output register block.
- Serializes slave read bytes for SDR private reads (I3C T-bit) or legacy I2C reads (master ACK/NACK).
- Produces the combinational D inputs pin_SDA_out, pin_SDA_oena and pin_SDA_oena_rise0 one SCL rising edge ahead, so the pad stage registers them on the following SCL falling edge.
- Runs on the SCL-derived clock; pulls bytes from a TX holding buffer through a valid/ready handshake.

Parameters:
- TBIT_MODE, 1, ninth bit type: 1 = I3C T-bit (slave drives), 0 = I2C ACK (slave releases, samples master).
- CNT_W, 8, width of byte_cnt; saturates at all-ones.

Ports:
- clk_SCL  input  1  SCL-derived clock; all state updates on rising edge.
- RST  input  1  reset, synchronous, active-high; parent also asserts it on STOP/Sr.
- start_read  input  1  level; read phase begins (sampled in IDLE).
- abort  input  1  master abort or bus error; forces release.
- sda_in  input  1  SDA pad value, sampled on clk_SCL rising.
- tx_data  input  8  next byte, MSB first.
- tx_valid  input  1  tx_data valid.
- tx_last  input  1  tx_data is the final byte.
- tx_ready  output  1  byte consumed on this edge when tx_valid=1.
- pin_SDA_out  output  1  SDA value for pad stage.
- pin_SDA_oena  output  1  falling-edge output enable for pad stage.
- pin_SDA_oena_rise0  output  1  release-on-SCL-high request for pad stage.
- rd_done  output  1  one-cycle pulse; read phase finished.
- rd_status  output  2  valid with rd_done: 00 end, 01 NACK, 10 underrun, 11 abort; holds until next rd_done.
- byte_cnt  output  CNT_W  bytes fully sent since start; cleared on start.

Behaviour:
- Clock and reset: one clock (clk_SCL); reset synchronous, active-high (RST).
- Reset values: state=IDLE, all outputs 0, rd_status=00, byte_cnt=0.
- States: IDLE, DATA (bit index 7..0), NINTH, DONE.
- tx_ready (combinational) = (IDLE & start_read & ~abort) | (NINTH & cont & ~abort).
  - In TBIT_MODE=0, cont = ~sda_in.
  - A load happens only on an edge where tx_ready & tx_valid.
- IDLE, start_read=1:
  - tx_valid=1: load shift register, oena=1, out=tx_data[7], byte_cnt=0, go to DATA at index 7.
  - tx_valid=0: go to DONE with status 10; SDA is never driven.
- DATA, each rising edge:
  - index>0: decrement index and present the next bit; oena stays 1.
  - index=0: present the ninth bit, go to NINTH, byte_cnt+1 (saturating).
- Ninth bit presented:
  - TBIT_MODE=1, byte not last: out=1, oena=1, oena_rise0=1 (drive high, release while SCL high).
  - TBIT_MODE=1, byte last: out=0, oena=1, oena_rise0=0.
  - TBIT_MODE=0: oena=0, out=0.
- NINTH rising edge, TBIT_MODE=1:
  - Continue: tx_valid=1 loads the next byte (DATA, bit7 presented); tx_valid=0 → release, DONE status 10.
  - End: release, DONE status 00.
- NINTH rising edge, TBIT_MODE=0: sda_in=0 (ACK) follows the TBIT_MODE=1 continue path; sda_in=1 (NACK) → release, DONE status 01.
- DONE: rd_done=1 for exactly one cycle, outputs released (oena=0, out=0, rise0=0), then IDLE. start_read is ignored until it is low for at least one edge (re-arm).
- abort:
  - Combinationally gates pin_SDA_oena and pin_SDA_oena_rise0 to 0.
  - Sampled high in DATA/NINTH → DONE status 11; abort has priority over a simultaneous load.
- RST mid-byte: next edge returns to IDLE with outputs 0; no rd_done pulse.
- pin_SDA_out is 0 whenever oena=0.
- pin_SDA_oena_rise0 is high only during a continue T-bit.

Test Plan:
- TBIT_MODE=1, single byte 0xA5 with tx_last=1:
  - Required: out sequence 1,0,1,0,0,1,0,1 then T=0, all with oena=1.
  - Required: rd_done one edge after the T-bit, status 00, byte_cnt=1.
- TBIT_MODE=1, bytes 0x3C then 0xFF (last):
  - Required: first T-bit out=1, oena=1, rise0=1.
  - Required: tx_ready pulses at start and at the first T-bit; second T-bit=0; byte_cnt=2, status 00.
- TBIT_MODE=1, 0x12 not last, tx_valid=0 at its T-bit → bus released, rd_done, status 10, byte_cnt=1.
- TBIT_MODE=0, 0x81 then 0x7E:
  - ACK bits: oena=0 on both.
  - Required: sda_in=0 at the first ACK continues; sda_in=1 at the second gives status 01, byte_cnt=2.
- abort raised at bit index 4 of 0xF0 → oena=0 in the same cycle; next edge DONE, status 11, tx_ready stays 0.
- RST asserted at bit index 2 → next edge all outputs 0, state IDLE, no rd_done; a fresh start_read with 0x55 serializes correctly.
